// File: rtl/sobol_gray_gen.sv
// Multi-dimension Sobol generator: WIDTH-cycle Gray-code seed for skip-ahead, then one point per
// accepted handshake via single-XOR Antonov-Saleev update; direction numbers runtime-loadable.
module sobol_gray_gen #(
  parameter int WIDTH = 32,
  parameter int M     = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [$clog2(M)-1:0]   cfg_dim,
  input  logic [$clog2(WIDTH)-1:0] cfg_bit,
  input  logic [WIDTH-1:0]       cfg_data,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [WIDTH-1:0]       start_idx,
  input  logic [CNT_W-1:0]       start_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_idx,
  output logic [M*WIDTH-1:0]     out_pt,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  localparam int DW = $clog2(M);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

  state_t                     state_q, state_d;
  logic [WIDTH-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           rem_q, rem_d;
  logic [BW-1:0]              b_q, b_d;
  logic [M-1:0][WIDTH-1:0]    x_q, x_d;
  logic [M-1:0][WIDTH-1:0]    pt_q, pt_d;
  logic [WIDTH-1:0]           out_idx_q, out_idx_d;
  logic                       out_valid_q, out_valid_d;
  logic                       done_q, done_d;
  logic                       ovf_q, ovf_d;
  logic [WIDTH-1:0]           v_q [M][WIDTH];

  logic [WIDTH-1:0]           gray;
  logic [BW-1:0]              low0;
  logic                       v_we;

  assign gray        = idx_q ^ (idx_q >> 1);
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_pt      = pt_q;
  assign done        = done_q;
  assign ovf         = ovf_q;
  assign v_we        = cfg_we && (state_q == IDLE);

  // Lowest clear bit of idx selects the single direction number that changes between
  // consecutive Gray codes. All-ones idx never reaches the update path.
  always_comb begin
    low0 = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!idx_q[i]) low0 = BW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    b_d         = b_q;
    x_d         = x_q;
    pt_d        = pt_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          idx_d = start_idx;
          rem_d = start_count;
          x_d   = '0;
          ovf_d = 1'b0;
          b_d   = '0;
          if (start_count == '0) done_d = 1'b1;
          else                   state_d = SEED;
        end
      end
      SEED: begin
        if (gray[b_q]) begin
          for (int d = 0; d < M; d++) x_d[d] = x_q[d] ^ v_q[d][b_q];
        end
        b_d = b_q + 1'b1;
        if (b_q == BW'(WIDTH - 1)) begin
          pt_d        = x_d;
          out_idx_d   = idx_q;
          out_valid_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (rem_q == CNT_W'(1)) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (&out_idx_q) begin
            // Stop rather than present the wrapped index 0.
            ovf_d       = 1'b1;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            for (int d = 0; d < M; d++) x_d[d] = x_q[d] ^ v_q[d][low0];
            idx_d     = idx_q + 1'b1;
            rem_d     = rem_q - 1'b1;
            pt_d      = x_d;
            out_idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      b_q         <= '0;
      x_q         <= '0;
      pt_q        <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      b_q         <= b_d;
      x_q         <= x_d;
      pt_q        <= pt_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  // Full decode of the dimension: indices beyond M-1 match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < M; d++)
        for (int k = 0; k < WIDTH; k++) v_q[d][k] <= '0;
    end else begin
      for (int d = 0; d < M; d++)
        for (int k = 0; k < WIDTH; k++)
          if (v_we && cfg_dim == DW'(d) && cfg_bit == BW'(k)) v_q[d][k] <= cfg_data;
    end
  end

endmodule
